// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM bus controller: FSM state encoding and strobe counter width.
package sram_ctrl_pkg;
  localparam int STROBE_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_e;
endpackage

// File: rtl/sram_io_pad.sv
// Tristate driver for the SRAM data bus; the only driver of sram_d in the controller.
module sram_io_pad #(
  parameter int DW = 4
) (
  input  logic          drv_en,
  input  logic [DW-1:0] dout,
  output logic [DW-1:0] din,
  inout  wire  [DW-1:0] sram_d
);
  assign sram_d = drv_en ? dout : {DW{1'bz}};
  assign din    = sram_d;
endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-beat valid/ready controller for an asynchronous SRAM with active-low nCS/nWE/nOE.
// Optional write-verify read-back (sticky wr_err) is built when SRAM_CTRL_WRVERIFY_EN is defined.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW         = 4,
  parameter int DW         = 4,
  parameter int STROBE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_err,
  output logic          busy,
  output logic          sram_ncs,
  output logic          sram_nwe,
  output logic          sram_noe,
  output logic [AW-1:0] sram_a,
  inout  wire  [DW-1:0] sram_d
);
  localparam logic [STROBE_CNT_W-1:0] STROBE_LOAD = STROBE_CNT_W'(STROBE_CYC - 1);

  state_e                  state_q;
  logic                    ncs_q, nwe_q, noe_q, drv_en_q;
  logic                    we_q, rsp_valid_q;
  logic [AW-1:0]           addr_q;
  logic [DW-1:0]           wdata_q, rdata_q, din;
  logic [STROBE_CNT_W-1:0] cnt_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
  logic                    wr_err_q, vfy_q, vpend_q;
`endif

  sram_io_pad #(.DW(DW)) u_pad (
    .drv_en (drv_en_q),
    .dout   (wdata_q),
    .din    (din),
    .sram_d (sram_d)
  );

  // All bus outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ncs_q       <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      drv_en_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
      wr_err_q    <= 1'b0;
      vfy_q       <= 1'b0;
      vpend_q     <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q  <= SETUP;
          ncs_q    <= 1'b0;
          addr_q   <= req_addr;
          we_q     <= req_we;
          wdata_q  <= req_wdata;
          drv_en_q <= req_we;
          cnt_q    <= STROBE_LOAD;
`ifdef SRAM_CTRL_WRVERIFY_EN
          vfy_q    <= 1'b0;
`endif
        end
        SETUP: begin
          state_q <= STROBE;
          nwe_q   <= ~we_q;
          noe_q   <= we_q;
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q <= HOLD;
            nwe_q   <= 1'b1;
            noe_q   <= 1'b1;
            if (!we_q) begin
              rdata_q     <= din;
              rsp_valid_q <= 1'b1;
`ifdef SRAM_CTRL_WRVERIFY_EN
              if (vfy_q && (din != wdata_q)) wr_err_q <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          ncs_q    <= 1'b1;
          drv_en_q <= 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
          state_q  <= TURN;
          vpend_q  <= we_q;
`else
          state_q  <= we_q ? IDLE : TURN;
`endif
        end
        TURN: begin
`ifdef SRAM_CTRL_WRVERIFY_EN
          // A write's bus-release cycle leads straight into the read-back of the same address.
          if (vpend_q) begin
            state_q <= SETUP;
            ncs_q   <= 1'b0;
            we_q    <= 1'b0;
            vfy_q   <= 1'b1;
            vpend_q <= 1'b0;
            cnt_q   <= STROBE_LOAD;
          end else begin
            state_q <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_ncs  = ncs_q;
  assign sram_nwe  = nwe_q;
  assign sram_noe  = noe_q;
  assign sram_a    = addr_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
  assign wr_err    = wr_err_q;
`else
  assign wr_err    = 1'b0;
`endif
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed self-checking bench for sram_bus_ctrl with a behavioural async SRAM on the bus.
module tb_sram_bus_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [3:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, wr_err, busy;
  logic       sram_ncs, sram_nwe, sram_noe;
  logic [3:0] rsp_rdata, sram_a;
  wire  [3:0] sram_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_bus_ctrl #(.AW(4), .DW(4), .STROBE_CYC(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_err(wr_err), .busy(busy),
    .sram_ncs(sram_ncs), .sram_nwe(sram_nwe), .sram_noe(sram_noe),
    .sram_a(sram_a), .sram_d(sram_d)
  );

  // Behavioural SRAM: writes while nCS/nWE low, drives the bus while nCS/nOE low.
  logic [3:0] mem [16] = '{default: 4'h0};
  always @(posedge clk) if (!sram_ncs && !sram_nwe) mem[sram_a] <= sram_d;
  assign sram_d = (!sram_ncs && !sram_noe && sram_nwe) ? mem[sram_a] : 4'bz;

  // Two extra instances for strobe-length extremes; only timing is observed on them.
  logic       aux_valid = 1'b0, aux_we = 1'b0;
  logic       s1_ready, s1_rv, s1_err, s1_busy, s1_ncs, s1_nwe, s1_noe;
  logic       s15_ready, s15_rv, s15_err, s15_busy, s15_ncs, s15_nwe, s15_noe;
  logic [3:0] s1_rd, s1_a, s15_rd, s15_a;
  wire  [3:0] s1_d, s15_d;

  sram_bus_ctrl #(.AW(4), .DW(4), .STROBE_CYC(1)) u_s1 (
    .clk(clk), .rst(rst), .req_valid(aux_valid), .req_ready(s1_ready),
    .req_we(aux_we), .req_addr(4'h6), .req_wdata(4'h3),
    .rsp_valid(s1_rv), .rsp_rdata(s1_rd), .wr_err(s1_err), .busy(s1_busy),
    .sram_ncs(s1_ncs), .sram_nwe(s1_nwe), .sram_noe(s1_noe),
    .sram_a(s1_a), .sram_d(s1_d)
  );

  sram_bus_ctrl #(.AW(4), .DW(4), .STROBE_CYC(15)) u_s15 (
    .clk(clk), .rst(rst), .req_valid(aux_valid), .req_ready(s15_ready),
    .req_we(aux_we), .req_addr(4'h6), .req_wdata(4'h3),
    .rsp_valid(s15_rv), .rsp_rdata(s15_rd), .wr_err(s15_err), .busy(s15_busy),
    .sram_ncs(s15_ncs), .sram_nwe(s15_nwe), .sram_noe(s15_noe),
    .sram_a(s15_a), .sram_d(s15_d)
  );

  int c1_we = 0, c1_oe = 0, c1_busy = 0, c15_we = 0, c15_oe = 0, c15_busy = 0;
  always @(posedge clk) begin
    if (!s1_nwe)   c1_we++;
    if (!s1_noe)   c1_oe++;
    if (s1_busy)   c1_busy++;
    if (!s15_nwe)  c15_we++;
    if (!s15_noe)  c15_oe++;
    if (s15_busy)  c15_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-conflict invariants on the main instance, every cycle outside reset.
  logic p_drv = 1'b0, p_nwe = 1'b1, p_rst = 1'b1;
  always @(negedge clk) begin
    logic drv, ok;
    drv = dut.drv_en_q;
    if (!rst && !p_rst) begin
      ok = !(drv && !sram_noe) && !(!sram_nwe && !sram_noe)
           && !(drv && !p_drv && !sram_noe) && !(!drv && p_drv && !p_nwe);
      tests++;
      assert (ok) else begin
        fails++;
        $error("FAIL bus_invariant: observed drv=%0b nwe=%0b noe=%0b prev_drv=%0b prev_nwe=%0b required no conflict",
               drv, sram_nwe, sram_noe, p_drv, p_nwe);
      end
    end
    p_drv = drv;
    p_nwe = sram_nwe;
    p_rst = rst;
  end

  task automatic do_op(input logic we, input logic [3:0] a, input logic [3:0] wd,
                       input logic [3:0] exp_rd, input string tag);
    int lat, nv, vc;
    logic [3:0] rd;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd;
    lat = 1; nv = 0; vc = 0; rd = '0;
    while (busy && lat < 60) begin
      if (rsp_valid) begin nv++; vc = lat; rd = rsp_rdata; end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat - 1), we ? 32'd4 : 32'd5);
    chk({tag, "_nvalid"}, 32'(nv), we ? 32'd0 : 32'd1);
    if (!we) begin
      chk({tag, "_vcyc"}, 32'(vc), 32'd4);
      chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    end
  endtask

  task automatic aux_op(input logic we);
    int b1, b15, s1, s15, n;
    b1 = c1_busy; b15 = c15_busy;
    s1 = we ? c1_we : c1_oe;
    s15 = we ? c15_we : c15_oe;
    @(negedge clk);
    aux_we = we; aux_valid = 1'b1;
    @(negedge clk);
    aux_valid = 1'b0;
    n = 0;
    while ((s1_busy || s15_busy) && n < 40) begin @(negedge clk); n++; end
    chk(we ? "s1_wr_strobe" : "s1_rd_strobe", 32'((we ? c1_we : c1_oe) - s1), 32'd1);
    chk(we ? "s15_wr_strobe" : "s15_rd_strobe", 32'((we ? c15_we : c15_oe) - s15), 32'd15);
    chk(we ? "s1_wr_lat" : "s1_rd_lat", 32'(c1_busy - b1), we ? 32'd3 : 32'd4);
    chk(we ? "s15_wr_lat" : "s15_rd_lat", 32'(c15_busy - b15), we ? 32'd17 : 32'd18);
  endtask

  initial begin
    int n;
    // Reset with a request present: it must not be accepted.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h9; req_wdata = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_ncs", 32'(sram_ncs), 32'd1);
    chk("rst_nwe", 32'(sram_nwe), 32'd1);
    chk("rst_noe", 32'(sram_noe), 32'd1);
    chk("rst_drv", 32'(dut.drv_en_q), 32'd0);
    chk("rst_addr", 32'(sram_a), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ignored", 32'(busy), 32'd0);

    do_op(1'b1, 4'h2, 4'hA, 4'h0, "wr2a");
    do_op(1'b0, 4'h2, 4'h0, 4'hA, "rd2a");
    do_op(1'b1, 4'hA, 4'h5, 4'h0, "wrA5");
    do_op(1'b1, 4'h2, 4'hE, 4'h0, "wr2e");
    do_op(1'b0, 4'hA, 4'h0, 4'h5, "rdA");
    do_op(1'b0, 4'h2, 4'h0, 4'hE, "rd2e");

    // Read 0x3 then write 0x3<-0x7 with req_valid held through the turnaround.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3;
    @(negedge clk);
    req_we = 1'b1; req_wdata = 4'h7;
    chk("b2b_setup_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    chk("turn_ready", 32'(req_ready), 32'd0);
    chk("turn_strobes", {29'd0, sram_ncs, sram_nwe, sram_noe}, 32'h7);
    chk("turn_drv", 32'(dut.drv_en_q), 32'd0);
    chk("turn_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_wr_drv", 32'(dut.drv_en_q), 32'd1);
    chk("b2b_wr_bus", 32'(sram_d), 32'h7);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("b2b_wr_done", 32'(busy), 32'd0);
    do_op(1'b0, 4'h3, 4'h0, 4'h7, "rd3");

    // Reset asserted during the write strobe.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_wdata = 4'h9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_nwe_low", 32'(sram_nwe), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_nwe", 32'(sram_nwe), 32'd1);
    chk("mid_ncs", 32'(sram_ncs), 32'd1);
    chk("mid_drv", 32'(dut.drv_en_q), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    do_op(1'b0, 4'h2, 4'h0, 4'hE, "rd2_after_rst");

    aux_op(1'b1);
    aux_op(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
